queue_wr_arbiter: RTL and testbench



---
 rtl/queue_wr_arbiter_if.sv | 23 ++
 rtl/queue_wr_arbiter.sv | 124 ++++++++++++
 tb/tb_queue_wr_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/queue_wr_arbiter_if.sv
// Write-side bundle between NUM_REQ byte producers, the arbiter and the byte queue.
// master: producers plus queue full flag; slave: the arbiter.
interface queue_wr_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 fifo_full;
  logic                 fifo_wr;
  logic [7:0]           fifo_data;

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_wr, fifo_data
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_wr, fifo_data
  );
endinterface

// File: rtl/queue_wr_arbiter.sv
// Packet-granular round-robin arbiter for one byte-queue write port; grant 1 cycle after request, write same cycle as handshake.
// fifo_full stalls the owner without loss. Optional QUEUE_WR_ARB_STATS_EN adds packet/truncation counters.
module queue_wr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MAX_PKT = 64
) (
  input  logic               clk,
  input  logic               rst,
  queue_wr_arbiter_if.slave  bus,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic               err_trunc
`ifdef QUEUE_WR_ARB_STATS_EN
  ,
  output logic [15:0]        pkt_count,
  output logic [15:0]        trunc_count
`endif
);

  localparam int CNT_W = (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1;
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic {IDLE, XFER} state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [IDX_W-1:0]   owner, owner_nxt;
  logic [IDX_W-1:0]   last_grant, last_grant_nxt;
  logic [CNT_W-1:0]   byte_cnt, byte_cnt_nxt;
  logic               err_trunc_nxt;

  logic               sel_vld;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W:0]     cand;
  logic               in_xfer;
  logic               hs;
  logic               pkt_done;
  logic               pkt_trunc;

  assign in_xfer   = (state == XFER);
  assign busy      = in_xfer;
  assign hs        = rst & in_xfer & bus.req_valid[owner] & ~bus.fifo_full;
  assign pkt_done  = hs & bus.req_last[owner];
  assign pkt_trunc = hs & ~bus.req_last[owner] & (byte_cnt == CNT_W'(MAX_PKT - 1));

  assign bus.req_ready = (rst && in_xfer && !bus.fifo_full) ? grant : '0;
  assign bus.fifo_wr   = hs;
  assign bus.fifo_data = in_xfer ? bus.req_data[{owner, 3'b000} +: 8] : 8'h00;

  // Search starts just after the previous owner and wraps, so every requester gets a turn.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_grant} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!sel_vld && bus.req_valid[cand[IDX_W-1:0]]) begin
        sel_vld = 1'b1;
        sel_idx = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    owner_nxt      = owner;
    last_grant_nxt = last_grant;
    byte_cnt_nxt   = byte_cnt;
    err_trunc_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (sel_vld) begin
          state_nxt    = XFER;
          grant_nxt    = NUM_REQ'(1) << sel_idx;
          owner_nxt    = sel_idx;
          byte_cnt_nxt = '0;
        end
      end
      XFER: begin
        if (hs) byte_cnt_nxt = byte_cnt + CNT_W'(1);
        if (pkt_done || pkt_trunc) begin
          state_nxt      = IDLE;
          grant_nxt      = '0;
          last_grant_nxt = owner;
          err_trunc_nxt  = pkt_trunc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      grant      <= '0;
      owner      <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      byte_cnt   <= '0;
      err_trunc  <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      owner      <= owner_nxt;
      last_grant <= last_grant_nxt;
      byte_cnt   <= byte_cnt_nxt;
      err_trunc  <= err_trunc_nxt;
    end
  end

`ifdef QUEUE_WR_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      pkt_count   <= '0;
      trunc_count <= '0;
    end else begin
      if (pkt_done)  pkt_count   <= pkt_count + 16'd1;
      if (pkt_trunc) trunc_count <= trunc_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_queue_wr_arbiter.sv
// Randomized bench for queue_wr_arbiter: producers stream packets, a cycle-level rule model predicts grants/writes,
// and a scoreboard of issued bytes per requester is popped on every queue write.
module tb_queue_wr_arbiter;
  localparam int NUM_REQ = 4;
  localparam int MAX_PKT = 4;

  typedef struct packed {
    logic       last;
    logic [7:0] dat;
  } byte_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  queue_wr_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();
  logic [NUM_REQ-1:0] grant;
  logic               busy;
  logic               err_trunc;
`ifdef QUEUE_WR_ARB_STATS_EN
  logic [15:0]        pkt_count;
  logic [15:0]        trunc_count;
`endif

  queue_wr_arbiter #(.NUM_REQ(NUM_REQ), .MAX_PKT(MAX_PKT)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .grant      (grant),
    .busy       (busy),
`ifdef QUEUE_WR_ARB_STATS_EN
    .pkt_count  (pkt_count),
    .trunc_count(trunc_count),
`endif
    .err_trunc  (err_trunc)
  );

  byte_t src   [NUM_REQ][$];   // bytes still to be handed over by each producer
  byte_t exp_q [NUM_REQ][$];   // bytes presented on the bus, awaiting their queue write
  int    errors = 0;
  int    checks = 0;
  logic  rst_req = 1'b1;
  logic  force_full = 1'b0;
  int    vld_pct = 100;
  int    full_pct = 0;
  logic [NUM_REQ-1:0] hs_pend = '0;

  // reference model state
  int m_owner = -1;
  int m_ptr = NUM_REQ - 1;
  int m_cnt = 0;
  logic m_trunc_due = 1'b0;
  int n_pkt = 0;
  int n_trunc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // producers: drive on the falling edge, note handshakes just after
  always @(negedge clk) begin
    rst = !rst_req;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (hs_pend[i]) begin
        void'(src[i].pop_front());
        bus.req_valid[i] = 1'b0;
      end
      if (!rst) begin
        src[i].delete();
        exp_q[i].delete();
        bus.req_valid[i] = 1'b0;
      end else if (!bus.req_valid[i] && src[i].size() > 0 && $urandom_range(99) < vld_pct) begin
        bus.req_valid[i]         = 1'b1;
        bus.req_data[8*i +: 8]   = src[i][0].dat;
        bus.req_last[i]          = src[i][0].last;
        exp_q[i].push_back(src[i][0]);
      end else if (!bus.req_valid[i]) begin
        bus.req_data[8*i +: 8] = 8'($urandom);
        bus.req_last[i]        = 1'($urandom);
      end
    end
    bus.fifo_full = force_full || ($urandom_range(99) < full_pct);
    #1;
    hs_pend = bus.req_valid & bus.req_ready;
  end

  // monitor + rule model: one evaluation per cycle, away from the clock edge
  logic [NUM_REQ-1:0] v, eg, er;
  logic ew, full, lst;
  byte_t e;
  always @(negedge clk) begin
    #2;
    v    = bus.req_valid;
    full = bus.fifo_full;
    eg   = (m_owner < 0) ? '0 : (NUM_REQ'(1) << m_owner);
    er   = (rst && m_owner >= 0 && !full) ? eg : '0;
    ew   = rst && m_owner >= 0 && v[m_owner] && !full;
    check("grant", 32'(grant), 32'(eg));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    check("err_trunc", 32'(err_trunc), 32'(m_trunc_due));
    check("req_ready", 32'(bus.req_ready), 32'(er));
    check("fifo_wr", 32'(bus.fifo_wr), 32'(ew));
    if (bus.fifo_wr === 1'b1) begin
      if (m_owner < 0 || exp_q[m_owner].size() == 0) begin
        check("fifo_data_unexpected", 32'(bus.fifo_data), 32'hFFFF_FFFF);
      end else begin
        e = exp_q[m_owner].pop_front();
        check("fifo_data", 32'(bus.fifo_data), 32'(e.dat));
      end
    end else if (m_owner < 0) begin
      check("fifo_data_idle", 32'(bus.fifo_data), 32'h0);
    end
    m_trunc_due = 1'b0;
    if (!rst) begin
      m_owner = -1;
      m_ptr   = NUM_REQ - 1;
      m_cnt   = 0;
      n_pkt   = 0;
      n_trunc = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (m_owner < 0 && v[(m_ptr + k) % NUM_REQ]) begin
          m_owner = (m_ptr + k) % NUM_REQ;
          m_cnt   = 0;
        end
      end
    end else if (ew) begin
      m_cnt++;
      lst = bus.req_last[m_owner];
      if (lst || m_cnt == MAX_PKT) begin
        if (lst) n_pkt++;
        else begin
          n_trunc++;
          m_trunc_due = 1'b1;
        end
        m_ptr   = m_owner;
        m_owner = -1;
      end
    end
  end

  task automatic add_pkt(input int r, input int len, input logic [7:0] base);
    byte_t b;
    for (int j = 0; j < len; j++) begin
      b.dat  = base + 8'(j);
      b.last = (j == len - 1);
      src[r].push_back(b);
    end
  endtask

  function automatic bit any_src();
    bit a = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) if (src[i].size() > 0) a = 1'b1;
    return a;
  endfunction

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((any_src() || m_owner >= 0) && n < limit) begin
      @(posedge clk);
      n++;
    end
    if (n >= limit) check("drain_timeout", 32'(n), 32'(0));
    repeat (3) @(posedge clk);
  endtask

`ifdef QUEUE_WR_ARB_STATS_EN
  task automatic check_stats();
    check("pkt_count", 32'(pkt_count), 32'(n_pkt[15:0]));
    check("trunc_count", 32'(trunc_count), 32'(n_trunc[15:0]));
  endtask
`endif

  initial begin
    int n;
    repeat (3) @(posedge clk);
    rst_req = 1'b0;
    repeat (2) @(posedge clk);

    // single 3-byte packet from requester 0
    add_pkt(0, 3, 8'hA1);
    wait_idle(200);

    // two requesters alternating 2-byte packets
    add_pkt(1, 2, 8'h10); add_pkt(1, 2, 8'h12);
    add_pkt(3, 2, 8'h30); add_pkt(3, 2, 8'h32);
    wait_idle(200);

    // queue full for three cycles mid-packet
    add_pkt(2, 4, 8'h50);
    n = 0;
    while (busy !== 1'b1 && n < 50) begin @(posedge clk); n++; end
    if (n >= 50) check("busy_timeout", 32'(n), 32'(0));
    @(posedge clk);
    force_full = 1'b1;
    repeat (3) @(posedge clk);
    force_full = 1'b0;
    wait_idle(200);

    // 6-byte packet truncated at MAX_PKT, remainder re-arbitrated
    add_pkt(0, 6, 8'h60);
    wait_idle(200);
`ifdef QUEUE_WR_ARB_STATS_EN
    check_stats();
`endif

    // reset after two bytes of a five-byte packet
    add_pkt(1, 5, 8'h70);
    n = 0;
    while (src[1].size() > 3 && n < 50) begin @(posedge clk); n++; end
    if (n >= 50) check("reset_setup_timeout", 32'(n), 32'(0));
    rst_req = 1'b1;
    @(posedge clk);
    rst_req = 1'b0;
    @(posedge clk);
    add_pkt(2, 1, 8'h80);
    add_pkt(0, 1, 8'h90);
    wait_idle(200);

    // three complete packets plus one truncation (its 1-byte tail completes a fourth)
    add_pkt(3, 2, 8'hB0);
    add_pkt(1, 5, 8'hC0);
    wait_idle(200);
`ifdef QUEUE_WR_ARB_STATS_EN
    check_stats();
`endif

    // randomized traffic with backpressure and valid gaps
    vld_pct  = 70;
    full_pct = 20;
    for (int r = 0; r < NUM_REQ; r++)
      for (int p = 0; p < 10; p++)
        add_pkt(r, $urandom_range(6, 1), 8'($urandom));
    wait_idle(20000);
    vld_pct  = 100;
    full_pct = 0;
`ifdef QUEUE_WR_ARB_STATS_EN
    check_stats();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
